shared_timer_arbiter: RTL and testbench
=======================================

# shared_timer_arbiter

Round-robin arbiter and sequencer for one shared down-counting interval timer. It serves NREQ requesters. Each requester presents an interval length. The block grants the timer to one requester at a time, loads and runs the counter, and signals completion with a one-cycle done pulse. It sits between independent control FSMs that need timed waits and a single counter datapath. This avoids instantiating one counter per requester.

## Interface
- NREQ, 4: number of requesters; legal range 2..16.
- WIDTH, 8: counter and interval-length width in bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  count enable (tick); the counter decrements only on cycles where en=1.
- req  in  NREQ  per-requester request level; must be held until done or deliberately dropped to abort.
- len  in  NREQ*WIDTH  per-requester interval; slice i is len[i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot grant, or all-zero.
- done  out  NREQ  one-cycle completion pulse to the served requester.
- busy  out  1  high in RUN and DONE.
- count  out  WIDTH  current timer value.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- Reset (rst_n=0, asynchronous) forces the following values:
  - state=IDLE
  - gnt=0, done=0, busy=0, count=0
  - round-robin pointer ptr=0
- Reset asserted mid-interval discards the interval; no done is produced.
- IDLE, req=0: remain in IDLE with all outputs 0.
- IDLE, req≠0: arbitrate.
  - Winner w is the first set req bit searching upward from ptr, wrapping modulo NREQ.
  - Next cycle: state=RUN, gnt=onehot(w), busy=1, count=len slice w, ptr=(w+1) mod NREQ.
- len is sampled only at the grant edge. Later changes to any len slice are ignored for the current interval.
- RUN rules, in priority order:
  - req[w]=0 (abort): next cycle go to IDLE with gnt=0, busy=0, count=0, and no done pulse.
  - count=0: next cycle go to DONE with done[w]=1 and gnt held. en is ignored for this transition.
  - en=1 and count≠0: count ← count−1.
  - en=0: hold.
- DONE lasts exactly one cycle. Next cycle: state=IDLE, gnt=0, done=0, busy=0, count=0.
  - done pulses even if req[w] drops during the DONE cycle.
- No re-arbitration happens in RUN or DONE. A new grant is issued only from IDLE. Requests arriving in the meantime wait.
- A requester that keeps req high after done re-enters arbitration normally. Because ptr advanced, every other pending requester is served first (fairness).
- The counter never wraps: it stops at 0 and never decrements below it. len=0 is legal and completes without counting.
- Arithmetic is unsigned, WIDTH bits. ptr is $clog2(NREQ) bits and wraps from NREQ−1 to 0.

## Timing
- Arbitration: req sampled in IDLE at edge t gives gnt and count=L visible after edge t+1.
- Interval with en held at 1 and length L:
  - count reaches 0 after edge t+1+L.
  - done is high in the cycle after edge t+2+L.
  - IDLE is entered at edge t+3+L.
- Back-to-back grants: the next gnt appears after edge t+4+L. The minimum gap between grants is 2 idle-ish cycles (DONE, IDLE).
- len=0: done follows 1 cycle after gnt.
- Abort latency: gnt drops 1 cycle after req[w] falls.
- en duty cycle stretches RUN by exactly the number of en=0 cycles. DONE timing does not depend on en.
- gnt is one-hot or zero in every cycle. done is a subset of the gnt bit in the same cycle.

## Test plan
- Single requester: NREQ=4, req=0001, len0=3, en=1.
  - Expected: gnt=0001 for 5 cycles; count 3,2,1,0; done=0001 exactly once, coinciding with the last gnt cycle; then all outputs 0.
- Round-robin: req=1111 held, all len=1.
  - Expected grant order 0001, 0010, 0100, 1000, 0001; each gnt lasts 3 cycles; no starvation; ptr wraps 3→0.
- Enable gating: req=0010, len1=2, en toggling 1,0,1,0,…
  - Expected: count holds on en=0 cycles; done arrives 2 cycles later than with en=1.
- Abort:
  - req0 granted with len=10; drop req0 when count=6. Expected: gnt=0 and count=0 next cycle, no done.
  - Drop req0 in the same cycle count=0. Expected: abort wins, no done.
- Zero length: req=0100, len2=0. Expected: gnt=0100 with count=0 for 2 cycles, done=0100 in the second cycle.
- Reset mid-RUN: assert rst_n=0 asynchronously while count=5.
  - Expected: all outputs 0 immediately, no done, ptr=0; after release with req=1000, grant goes to requester 3.

Source files
------------

// File: rtl/shared_timer_arbiter_if.sv
// Bundle of signals between the requester side and the shared timer.
//
// Handshake: a requester raises req[i] with its interval on len slice i and
// keeps req[i] high; the timer answers with a one-hot gnt, counts the interval
// down on en ticks, and then pulses done[i] for one cycle together with gnt[i].
// Dropping req[i] while granted aborts the interval (gnt falls, no done).
// len is sampled only on the edge that issues the grant.
interface shared_timer_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic                    en;
    logic [NREQ-1:0]         req;
    logic [NREQ*WIDTH-1:0]   len;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         done;
    logic                    busy;
    logic [WIDTH-1:0]        count;

    // Requester side: drives requests, lengths and the tick.
    modport master (
        output en, req, len,
        input  gnt, done, busy, count
    );

    // Timer side: consumes requests, drives grant/completion status.
    modport slave (
        input  en, req, len,
        output gnt, done, busy, count
    );
endinterface

// File: rtl/shared_timer_arbiter.sv
// Round-robin arbiter + sequencer for one shared down-counting interval timer.
// One requester owns the counter at a time; completion is a one-cycle done
// pulse to the owner. Grants are only issued from IDLE.
module shared_timer_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int PW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shared_timer_arbiter_if.slave bus,
    output logic [1:0]            state_o,
    output logic [PW-1:0]         ptr_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   done_q;
    logic              busy_q;
    logic [WIDTH-1:0]  count_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     widx_q;

    logic              win_found_d;
    logic [PW-1:0]     win_idx_d;
    logic [PW-1:0]     ptr_d;
    logic [WIDTH-1:0]  len_d;
    logic [NREQ-1:0]   gnt_d;

    // Winner search: first set req bit at or above ptr, wrapping modulo NREQ.
    // Scanning offsets from highest to lowest lets the smallest offset win.
    always_comb begin
        int          idx;
        logic [PW-1:0] cand;
        win_found_d = 1'b0;
        win_idx_d   = '0;
        idx         = 0;
        cand        = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx  = (int'(ptr_q) + k) % NREQ;
            cand = PW'(idx);
            if (bus.req[cand]) begin
                win_found_d = 1'b1;
                win_idx_d   = cand;
            end
        end
    end

    // Grant-edge values: next pointer, loaded interval and one-hot grant.
    always_comb begin
        ptr_d = (win_idx_d == PW'(NREQ - 1)) ? '0 : win_idx_d + 1'b1;
        len_d = bus.len[int'(win_idx_d)*WIDTH +: WIDTH];
        gnt_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_d;
    end

    // Sequencer FSM with all outputs registered. Abort outranks completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            ptr_q   <= '0;
            widx_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= '0;
                    if (win_found_d) begin
                        state_q <= S_RUN;
                        gnt_q   <= gnt_d;
                        busy_q  <= 1'b1;
                        count_q <= len_d;
                        ptr_q   <= ptr_d;
                        widx_q  <= win_idx_d;
                    end else begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        count_q <= '0;
                    end
                end
                S_RUN: begin
                    if (!bus.req[widx_q]) begin
                        state_q <= S_IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        count_q <= '0;
                    end else if (count_q == '0) begin
                        state_q <= S_DONE;
                        done_q  <= gnt_q;
                    end else if (bus.en) begin
                        count_q <= count_q - 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                    count_q <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.count = count_q;
    assign state_o   = state_q;
    assign ptr_o     = ptr_q;

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Bench for shared_timer_arbiter: vector table, corner sequences, random run
// against a transaction-level reference model.
module tb_shared_timer_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   state_dbg;
    logic [1:0]   ptr_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    shared_timer_arbiter_if #(.NREQ(N), .WIDTH(W)) bus ();

    shared_timer_arbiter #(.NREQ(N), .WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_dbg),
        .ptr_o   (ptr_dbg)
    );

    // clock
    always #5 clk = ~clk;

    // reference model: who owns the timer, how much is left, finishing flag
    int m_owner;
    int m_rem;
    bit m_fin;
    int m_ptr;

    function automatic logic [N*W-1:0] mk_len(input int i, input int v);
        logic [N*W-1:0] r;
        r = '0;
        r[i*W +: W] = W'(v);
        return r;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_rem   = 0;
        m_fin   = 1'b0;
        m_ptr   = 0;
    endtask

    // One clock edge of the spec's rules, applied to the inputs seen at the edge.
    task automatic model_step();
        int w;
        if (m_fin) begin
            m_fin   = 1'b0;
            m_owner = -1;
            m_rem   = 0;
        end else if (m_owner >= 0) begin
            if (!bus.req[m_owner]) begin
                m_owner = -1;
                m_rem   = 0;
            end else if (m_rem == 0) begin
                m_fin = 1'b1;
            end else if (bus.en) begin
                m_rem = m_rem - 1;
            end
        end else begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            if (w >= 0) begin
                m_owner = w;
                m_rem   = int'(bus.len[w*W +: W]);
                m_ptr   = (w + 1) % N;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        ed = m_fin ? eg : '0;
        check("model_gnt",   32'(bus.gnt),   32'(eg));
        check("model_done",  32'(bus.done),  32'(ed));
        check("model_busy",  32'(bus.busy),  32'(m_owner >= 0));
        check("model_count", 32'(bus.count), 32'(m_rem));
        check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
        check("done_in_gnt", 32'(bus.done & ~bus.gnt), 32'd0);
    endtask

    // one clock: model follows the edge, outputs checked on the falling edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0]   req;
        logic           en;
        logic [N*W-1:0] len;
        logic [N-1:0]   e_gnt;
        logic [N-1:0]   e_done;
        logic           e_busy;
        logic [W-1:0]   e_cnt;
    } vec_t;

    vec_t vecs[18];
    logic [N-1:0] exp_q[$];

    initial begin
        logic [N-1:0] g;
        int           n;
        int           t;

        // vectors: single requester len 3, zero length, en gating
        vecs[0]  = '{4'b0001, 1'b1, mk_len(0, 3), 4'b0001, 4'b0000, 1'b1, 8'd3};
        vecs[1]  = '{4'b0001, 1'b1, mk_len(0, 3), 4'b0001, 4'b0000, 1'b1, 8'd2};
        vecs[2]  = '{4'b0001, 1'b1, mk_len(0, 3), 4'b0001, 4'b0000, 1'b1, 8'd1};
        vecs[3]  = '{4'b0001, 1'b1, mk_len(0, 3), 4'b0001, 4'b0000, 1'b1, 8'd0};
        vecs[4]  = '{4'b0001, 1'b1, mk_len(0, 3), 4'b0001, 4'b0001, 1'b1, 8'd0};
        vecs[5]  = '{4'b0000, 1'b1, mk_len(0, 3), 4'b0000, 4'b0000, 1'b0, 8'd0};
        vecs[6]  = '{4'b0000, 1'b1, mk_len(0, 3), 4'b0000, 4'b0000, 1'b0, 8'd0};
        vecs[7]  = '{4'b0100, 1'b1, mk_len(2, 0), 4'b0100, 4'b0000, 1'b1, 8'd0};
        vecs[8]  = '{4'b0100, 1'b1, mk_len(2, 0), 4'b0100, 4'b0100, 1'b1, 8'd0};
        vecs[9]  = '{4'b0000, 1'b1, mk_len(2, 0), 4'b0000, 4'b0000, 1'b0, 8'd0};
        vecs[10] = '{4'b0000, 1'b1, mk_len(2, 0), 4'b0000, 4'b0000, 1'b0, 8'd0};
        vecs[11] = '{4'b0010, 1'b1, mk_len(1, 2), 4'b0010, 4'b0000, 1'b1, 8'd2};
        vecs[12] = '{4'b0010, 1'b0, mk_len(1, 9), 4'b0010, 4'b0000, 1'b1, 8'd2};
        vecs[13] = '{4'b0010, 1'b1, mk_len(1, 9), 4'b0010, 4'b0000, 1'b1, 8'd1};
        vecs[14] = '{4'b0010, 1'b0, mk_len(1, 9), 4'b0010, 4'b0000, 1'b1, 8'd1};
        vecs[15] = '{4'b0010, 1'b1, mk_len(1, 9), 4'b0010, 4'b0000, 1'b1, 8'd0};
        vecs[16] = '{4'b0010, 1'b0, mk_len(1, 9), 4'b0010, 4'b0010, 1'b1, 8'd0};
        vecs[17] = '{4'b0000, 1'b1, mk_len(1, 9), 4'b0000, 4'b0000, 1'b0, 8'd0};

        // reset state
        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.req = '0;
        bus.len = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_gnt",   32'(bus.gnt),   32'd0);
        check("rst_done",  32'(bus.done),  32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_ptr",   32'(ptr_dbg),   32'd0);
        rst_n = 1'b1;

        // table-driven vectors
        for (int i = 0; i < 18; i++) begin
            bus.req = vecs[i].req;
            bus.en  = vecs[i].en;
            bus.len = vecs[i].len;
            cycle();
            check($sformatf("vec%0d_gnt", i),   32'(bus.gnt),   32'(vecs[i].e_gnt));
            check($sformatf("vec%0d_done", i),  32'(bus.done),  32'(vecs[i].e_done));
            check($sformatf("vec%0d_busy", i),  32'(bus.busy),  32'(vecs[i].e_busy));
            check($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].e_cnt));
        end

        // round-robin with all requesters held, len=1
        do_reset();
        bus.req = 4'b1111;
        bus.en  = 1'b1;
        bus.len = {N{8'd1}};
        exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        while (exp_q.size() > 0) begin
            t = 0;
            while (bus.gnt == '0 && t < 20) begin
                cycle();
                t++;
            end
            check("rr_wait", 32'(t < 20), 32'd1);
            g = exp_q.pop_front();
            check("rr_order", 32'(bus.gnt), 32'(g));
            n = 0;
            g = bus.gnt;
            while (bus.gnt == g && n < 10) begin
                n++;
                cycle();
            end
            check("rr_len", 32'(n), 32'd3);
        end
        bus.req = '0;
        repeat (2) cycle();

        // abort at count=6
        do_reset();
        bus.req = 4'b0001;
        bus.len = mk_len(0, 10);
        bus.en  = 1'b1;
        t = 0;
        do begin
            cycle();
            t++;
        end while (bus.count != 8'd6 && t < 30);
        check("abort6_reach", 32'(bus.count), 32'd6);
        bus.req = '0;
        cycle();
        check("abort6_gnt",   32'(bus.gnt),   32'd0);
        check("abort6_count", 32'(bus.count), 32'd0);
        check("abort6_done",  32'(bus.done),  32'd0);
        cycle();
        check("abort6_nodone", 32'(bus.done), 32'd0);

        // abort in the cycle count=0: abort wins
        bus.req = 4'b0001;
        bus.len = mk_len(0, 2);
        t = 0;
        do begin
            cycle();
            t++;
        end while (!(bus.busy && bus.count == 8'd0) && t < 30);
        check("abort0_reach", 32'(bus.gnt), 32'b0001);
        bus.req = '0;
        cycle();
        check("abort0_gnt",  32'(bus.gnt),  32'd0);
        check("abort0_done", 32'(bus.done), 32'd0);
        cycle();
        check("abort0_nodone", 32'(bus.done), 32'd0);

        // asynchronous reset mid-interval
        do_reset();
        bus.req = 4'b0010;
        bus.len = mk_len(1, 9);
        t = 0;
        do begin
            cycle();
            t++;
        end while (bus.count != 8'd5 && t < 30);
        check("rstmid_reach", 32'(bus.count), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rstmid_gnt",   32'(bus.gnt),   32'd0);
        check("rstmid_done",  32'(bus.done),  32'd0);
        check("rstmid_busy",  32'(bus.busy),  32'd0);
        check("rstmid_count", 32'(bus.count), 32'd0);
        check("rstmid_ptr",   32'(ptr_dbg),   32'd0);
        bus.req = 4'b1000;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check("rstmid_regrant", 32'(bus.gnt), 32'b1000);
        bus.req = '0;
        repeat (3) cycle();

        // randomized run against the reference model
        do_reset();
        bus.req = '0;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < N; b++) begin
                if (!bus.req[b] && $urandom_range(0, 5) == 0) bus.req[b] = 1'b1;
                else if (bus.req[b] && $urandom_range(0, 39) == 0) bus.req[b] = 1'b0;
                if ($urandom_range(0, 3) == 0) bus.len[b*W +: W] = W'($urandom_range(0, 6));
            end
            bus.en = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
